// File: rtl/rc5_key_mix.sv
// RC5 key-expansion mixing stage.
// Fills the S table with the P/Q magic sequence, then runs 3*max(T,C) mixing
// iterations over S and L (4 cycles each) and raises done once the final
// round-key table is in S RAM. Both RAMs are external, single-port, with
// registered read data; every output of this block is a register.
module rc5_key_mix #(
  parameter int           W = 32,
  parameter int           T = 26,
  parameter int           C = 4,
  parameter logic [W-1:0] P = 32'hB7E15163,
  parameter logic [W-1:0] Q = 32'h9E3779B9,
  localparam int          T_length = $clog2(T),
  localparam int          C_length = $clog2(C),
  localparam int          N = 3 * ((T > C) ? T : C)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [T_length-1:0] S_address,
  input  logic [W-1:0]        S_sub_i,
  output logic [W-1:0]        S_sub_i_prima,
  output logic                S_we,
  output logic [C_length-1:0] L_address,
  input  logic [W-1:0]        L_sub_i,
  output logic [W-1:0]        L_sub_i_prima,
  output logic                L_we,
  output logic                done
);

  localparam int LGW = $clog2(W);     // rotation amount width
  localparam int KW  = $clog2(T + 1); // init counter must reach T
  localparam int NW  = $clog2(N + 1); // iteration counter

  localparam logic [KW-1:0]       K_END  = KW'(T);
  localparam logic [T_length-1:0] I_LAST = T_length'(T - 1);
  localparam logic [C_length-1:0] J_LAST = C_length'(C - 1);
  localparam logic [NW-1:0]       N_LAST = NW'(N - 1);
  localparam logic [LGW-1:0]      ROT3   = LGW'(3);

  typedef enum logic [2:0] {
    IDLE, INIT, MIX_ADDR, MIX_READ, MIX_WS, MIX_WL, DONE
  } state_t;

  state_t              state;
  logic [W-1:0]        a_reg, b_reg;
  logic [W-1:0]        init_val;   // P + k*Q for the next INIT write
  logic [KW-1:0]       k;
  logic [T_length-1:0] i;
  logic [C_length-1:0] j;
  logic [NW-1:0]       n;

  logic [W-1:0] a_next, x_sum, b_next;

  // Rotate left through a doubled word; an amount of 0 returns x unchanged.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                        input logic [LGW-1:0] s);
    logic [2*W-1:0] t;
    t = {x, x} << s;
    return t[2*W-1:W];
  endfunction

  // Mixing datapath. In MIX_WL a_reg already holds the freshly written A.
  assign a_next = rotl(S_sub_i + a_reg + b_reg, ROT3);
  assign x_sum  = a_reg + b_reg;
  assign b_next = rotl(L_sub_i + x_sum, x_sum[LGW-1:0]);

  // Control FSM with registered RAM-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      init_val      <= '0;
      k             <= '0;
      i             <= '0;
      j             <= '0;
      n             <= '0;
      S_address     <= '0;
      S_sub_i_prima <= '0;
      S_we          <= 1'b0;
      L_address     <= '0;
      L_sub_i_prima <= '0;
      L_we          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // First INIT write (S[0]=P) is presented right away so that the
            // T writes land on the T edges following start.
            state         <= INIT;
            done          <= 1'b0;
            L_we          <= 1'b0;
            S_address     <= '0;
            S_sub_i_prima <= P;
            S_we          <= 1'b1;
            k             <= KW'(1);
            init_val      <= P + Q;
          end else if (state == DONE) begin
            // Last L write lands on this edge; the table is final from here.
            done <= 1'b1;
            L_we <= 1'b0;
          end
        end
        INIT: begin
          if (k == K_END) begin
            S_we  <= 1'b0;
            state <= MIX_ADDR;
            a_reg <= '0;
            b_reg <= '0;
            i     <= '0;
            j     <= '0;
            n     <= '0;
          end else begin
            S_address     <= k[T_length-1:0];
            S_sub_i_prima <= init_val;
            init_val      <= init_val + Q;
            k             <= k + KW'(1);
          end
        end
        MIX_ADDR: begin
          S_address <= i;
          L_address <= j;
          S_we      <= 1'b0;
          L_we      <= 1'b0;
          state     <= MIX_READ;
        end
        MIX_READ: begin
          state <= MIX_WS;
        end
        MIX_WS: begin
          S_sub_i_prima <= a_next;
          S_we          <= 1'b1;
          a_reg         <= a_next;
          state         <= MIX_WL;
        end
        MIX_WL: begin
          // L address still points at j, so L_sub_i is L[j] here.
          S_we          <= 1'b0;
          L_sub_i_prima <= b_next;
          L_we          <= 1'b1;
          b_reg         <= b_next;
          i             <= (i == I_LAST) ? '0 : i + T_length'(1);
          j             <= (j == J_LAST) ? '0 : j + C_length'(1);
          n             <= n + NW'(1);
          state         <= (n == N_LAST) ? DONE : MIX_ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_key_mix.sv
// Scoreboard bench for rc5_key_mix: a behavioural RC5 key-mix model queues
// every expected RAM write (cycle, address, data) and the done edge; a
// negedge monitor pops and compares whatever the DUT presents.
module tb_rc5_key_mix;

  localparam int          W = 32;
  localparam int          T = 26;
  localparam int          C = 4;
  localparam int          N = 3 * ((T > C) ? T : C);
  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [4:0]  S_address;
  logic [31:0] S_sub_i, S_sub_i_prima;
  logic        S_we;
  logic [1:0]  L_address;
  logic [31:0] L_sub_i, L_sub_i_prima;
  logic        L_we;
  logic        done;

  rc5_key_mix #(.W(W), .T(T), .C(C), .P(P), .Q(Q)) dut (
    .clk(clk), .rst(rst), .start(start),
    .S_address(S_address), .S_sub_i(S_sub_i), .S_sub_i_prima(S_sub_i_prima),
    .S_we(S_we), .L_address(L_address), .L_sub_i(L_sub_i),
    .L_sub_i_prima(L_sub_i_prima), .L_we(L_we), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM models with registered read data.
  logic [31:0] s_ram [T];
  logic [31:0] l_ram [C];
  logic [31:0] ld_val [C];
  logic        ld_req = 1'b0;

  always @(posedge clk) begin
    if (S_we) s_ram[S_address] <= S_sub_i_prima;
    S_sub_i <= s_ram[S_address];
    if (ld_req) begin
      for (int x = 0; x < C; x++) l_ram[x] <= ld_val[x];
    end else if (L_we) begin
      l_ram[L_address] <= L_sub_i_prima;
    end
    L_sub_i <= l_ram[L_address];
  end

  typedef struct {
    int          cyc;
    int          a;
    logic [31:0] d;
  } ev_t;

  ev_t sq[$];
  ev_t lq[$];
  int  dq[$];

  logic [31:0] mk  [C];  // L contents the next run starts from
  logic [31:0] m_S [T];  // model's final tables
  logic [31:0] m_L [C];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    int r;
    r = s % 32;
    if (r == 0) return x;
    return (x << r) | (x >> (32 - r));
  endfunction

  // RC5 key mixing as written in RFC 2040, timestamped with the block's
  // cycle schedule relative to the start edge e.
  task automatic model(input int e);
    logic [31:0] s [T];
    logic [31:0] l [C];
    logic [31:0] a, b;
    int ii, jj;
    ev_t ev;
    for (int x = 0; x < C; x++) l[x] = mk[x];
    for (int k = 0; k < T; k++) begin
      s[k] = P + 32'(k) * Q;
      ev.cyc = e + k; ev.a = k; ev.d = s[k];
      sq.push_back(ev);
    end
    a = 0; b = 0; ii = 0; jj = 0;
    for (int it = 0; it < N; it++) begin
      a = rotl(s[ii] + a + b, 3);
      s[ii] = a;
      ev.cyc = e + T + 3 + 4 * it; ev.a = ii; ev.d = a;
      sq.push_back(ev);
      b = rotl(l[jj] + a + b, int'((a + b) & 32'd31));
      l[jj] = b;
      ev.cyc = e + T + 4 + 4 * it; ev.a = jj; ev.d = b;
      lq.push_back(ev);
      ii = (ii + 1) % T;
      jj = (jj + 1) % C;
    end
    dq.push_back(e + T + 4 * N + 1);
    for (int x = 0; x < T; x++) m_S[x] = s[x];
    for (int x = 0; x < C; x++) m_L[x] = l[x];
  endtask

  // Monitor: every write and the done rise must match the queued model.
  logic done_d = 1'b0;
  always @(negedge clk) begin
    ev_t ev;
    if (S_we) begin
      checks++;
      if (sq.size() == 0) begin
        failures++;
        $display("FAIL s_write unexpected at cyc=%0d addr=%0d data=%0h", cyc, S_address, S_sub_i_prima);
      end else begin
        ev = sq.pop_front();
        if (int'(S_address) != ev.a || S_sub_i_prima !== ev.d || cyc != ev.cyc) begin
          failures++;
          $display("FAIL s_write actual cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                   cyc, S_address, S_sub_i_prima, ev.cyc, ev.a, ev.d);
        end
      end
    end
    if (L_we) begin
      checks++;
      if (lq.size() == 0) begin
        failures++;
        $display("FAIL l_write unexpected at cyc=%0d addr=%0d data=%0h", cyc, L_address, L_sub_i_prima);
      end else begin
        ev = lq.pop_front();
        if (int'(L_address) != ev.a || L_sub_i_prima !== ev.d || cyc != ev.cyc) begin
          failures++;
          $display("FAIL l_write actual cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                   cyc, L_address, L_sub_i_prima, ev.cyc, ev.a, ev.d);
        end
      end
    end
    if (done && !done_d) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL done_rise unexpected at cyc=%0d", cyc);
      end else if (cyc != dq[0]) begin
        failures++;
        $display("FAIL done_rise actual cyc=%0d expected cyc=%0d", cyc, dq[0]);
        void'(dq.pop_front());
      end else begin
        void'(dq.pop_front());
      end
    end
    done_d = done;
  end

  task automatic flush();
    sq.delete();
    lq.delete();
    dq.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_addr"}, 64'(S_address), 64'd0);
    chk({tag, "_s_data"}, 64'(S_sub_i_prima), 64'd0);
    chk({tag, "_s_we"}, 64'(S_we), 64'd0);
    chk({tag, "_l_addr"}, 64'(L_address), 64'd0);
    chk({tag, "_l_data"}, 64'(L_sub_i_prima), 64'd0);
    chk({tag, "_l_we"}, 64'(L_we), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic load_key();
    @(negedge clk);
    for (int x = 0; x < C; x++) ld_val[x] = mk[x];
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Pulse start for one cycle; e is the edge that samples it.
  task automatic do_start(output int e);
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    model(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic glitch_at(input int c);
    while (cyc < c) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    for (int x = 0; x < T; x++) chk({tag, "_final_S"}, 64'(s_ram[x]), 64'(m_S[x]));
    for (int x = 0; x < C; x++) chk({tag, "_final_L"}, 64'(l_ram[x]), 64'(m_L[x]));
    chk({tag, "_s_queue_drained"}, 64'(sq.size()), 64'd0);
    chk({tag, "_l_queue_drained"}, 64'(lq.size()), 64'd0);
  endtask

  task automatic rand_key();
    for (int x = 0; x < C; x++) mk[x] = $urandom();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [127:0] gk;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Full run with the RFC 2040 example converted key, start glitches in
    // INIT and MIX must not disturb anything.
    gk = 128'hFFFEEEE58684FFF05FFE493853000434;
    for (int x = 0; x < C; x++) mk[x] = gk[32*x +: 32];
    load_key();
    do_start(e);
    glitch_at(e + 5);
    glitch_at(e + 100);
    wait_done("golden");

    // Restart from DONE: mixing resumes from the already-mixed L table.
    for (int x = 0; x < C; x++) mk[x] = m_L[x];
    do_start(e);
    chk("restart_done_fall", 64'(done), 64'd0);
    wait_done("restart");

    // Reset during iteration 10, then the same key must reproduce the run.
    rand_key();
    load_key();
    do_start(e);
    while (cyc < e + T + 1 + 40 + 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 flush();
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    load_key();
    do_start(e);
    wait_done("after_reset");

    // start and rst together mid-run: block must stay idle.
    rand_key();
    load_key();
    do_start(e);
    while (cyc < e + 60) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 flush();
    @(negedge clk);
    check_zero("start_rst");
    rst = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after_start_rst_done", 64'(done), 64'd0);
    chk("idle_after_start_rst_we", 64'({S_we, L_we}), 64'd0);

    // Another random key from IDLE.
    rand_key();
    load_key();
    do_start(e);
    wait_done("random");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
